par2ser_bit_feeder: RTL and testbench
=====================================

Name: par2ser_bit_feeder

Overview:
- Upstream stage of the 1101 overlapping sequence detector.
- Accepts parallel words over a valid/ready handshake and serializes them one bit per clock onto the detector's single-bit `in` input.
- Has a one-word pending buffer, so back-to-back words stream with no idle gap.
- Emits a bit-valid qualifier and a last-bit marker for downstream framing and debug.

Parameters:
- WIDTH, 8, bits per loaded word; legal values are 2 to 32.
- MSB_FIRST, 1, 1 shifts bit WIDTH-1 out first; 0 shifts bit 0 out first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_data  input  WIDTH  parallel word to serialize.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- out_bit  output  1  serial bit; drives the detector `in`.
- out_valid  output  1  out_bit carries a real data bit.
- last_bit  output  1  out_bit is the final bit of the current word.
- busy  output  1  a word is shifting or a word is pending.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; shift register, bit counter and pending buffer clear.
  - out_bit=0, out_valid=0, last_bit=0, busy=0, load_ready=1.
  - Reset mid-word drops both the in-flight word and the pending word. No partial word resumes after reset.
- Accept rule:
  - A word is transferred when load_valid && load_ready at a rising edge.
  - load_ready = !pend_full. It is combinational from registered state and never depends on load_valid.
- FSM states: IDLE, SHIFT.
- IDLE:
  - out_bit=0, out_valid=0. The detector sees zeros during gaps, and those zeros are part of its stream.
  - On accept: shreg <= load_data, cnt <= 0, state <= SHIFT.
  - Latency: the first bit appears on out_bit in the cycle after the accepting edge.
- SHIFT:
  - out_bit = current selected bit (MSB or LSB per MSB_FIRST), out_valid=1.
  - last_bit=1 when cnt==WIDTH-1.
  - Each edge advances cnt and shifts shreg by one bit.
  - An accept while in SHIFT writes the pending buffer and sets pend_full=1.
- End of word (edge where cnt==WIDTH-1), checked in priority order:
  - pend_full=1: shreg <= pending, pend_full <= 0, cnt <= 0, stay in SHIFT. No gap cycle.
  - pend_full=0 and accept on this edge: shreg <= load_data, cnt <= 0, stay in SHIFT. No gap cycle.
  - Otherwise: state <= IDLE, out_valid falls in the next cycle.
- Simultaneous events: on an end-of-word edge with pend_full=1, load_ready is 0, so no new accept can collide with the pending transfer. Ready rises the cycle after.
- Throughput: one bit per clock sustained.
- busy = (state==SHIFT) || pend_full.
- All outputs are registered or derived only from registered state. There is no combinational path from any input to out_bit, out_valid or last_bit.
- cnt width is clog2(WIDTH). It wraps to 0 only on a reload.

Decomposition:
- Shared package par2ser_pkg: state enum {IDLE, SHIFT}, default WIDTH constant, and a function computing the counter width.
- No sub-module is needed. The pending buffer is a single register plus a flag, kept inline.

Test Plan:
- Reset, then load 8'b1101_1010 once (MSB_FIRST=1) -> out_bit = 1,1,0,1,1,0,1,0 on 8 consecutive cycles starting one cycle after accept; out_valid=1 throughout; last_bit only on the 8th; then out_valid=0 and out_bit=0.
- Hold load_valid with 8'hD0 then 8'hFF -> 16 contiguous out_valid cycles with no gap; load_ready=0 while the second word is pending and 1 again the cycle after the end-of-word edge.
- MSB_FIRST=0, load 8'h0B -> out_bit = 1,1,0,1,0,0,0,0.
- Assert reset after 3 bits of 8'hFF with 8'hAA pending -> out_valid, out_bit and busy go to 0 immediately (asynchronously); after release, no bits are emitted until a new accept.
- Chain into the 1101 overlapping detector and load 8'b1101_1010 -> detector out pulses on the 4th and 7th serialized bits (overlap confirmed).
- Back-to-back accepts on every end-of-word edge with the pending buffer empty -> no gap cycle and no dropped word across 4 words (scoreboard compare).

Source files
------------

// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the parallel-to-serial bit feeder.
//   DEFAULT_WIDTH : default word width
//   state_t       : feeder FSM state encoding
//   cnt_width()   : bit-counter width for a given word width
package par2ser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must index 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/par2ser_bit_feeder_if.sv
// Load handshake and serial output bundle of the bit feeder.
//   load_data/load_valid/load_ready : word transfer (upstream -> feeder)
//   out_bit/out_valid/last_bit      : serial stream to the 1101 detector
//   busy                            : a word is shifting or pending
// slave  : the feeder side
// master : the producer / monitor side
interface par2ser_bit_feeder_if
    import par2ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             out_bit;
    logic             out_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output load_data, load_valid,
        input  load_ready, out_bit, out_valid, last_bit, busy
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, out_bit, out_valid, last_bit, busy
    );

endinterface

// File: rtl/par2ser_bit_feeder.sv
// Serializes parallel words one bit per clock onto the 1101 detector input.
// A one-word pending buffer lets consecutive words stream with no gap.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : par2ser_bit_feeder_if.slave (load handshake + serial outputs)
module par2ser_bit_feeder
    import par2ser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    par2ser_bit_feeder_if.slave   bus
);

    localparam int unsigned          CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   pend;
    logic               pend_full;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               end_of_word;
    logic               cur_bit;
    logic [WIDTH-1:0]   shreg_next;

    // Ready depends only on registered state, never on load_valid.
    assign accept      = bus.load_valid && !pend_full;
    assign end_of_word = (state == SHIFT) && (cnt == CNT_LAST);

    // Bit currently presented and the register after one shift step.
    always_comb begin
        cur_bit    = 1'b0;
        shreg_next = shreg;
        if (MSB_FIRST) begin
            cur_bit    = shreg[WIDTH-1];
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            cur_bit    = shreg[0];
            shreg_next = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // Feeder FSM, shift register, bit counter and pending buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= bus.load_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (end_of_word) begin
                        // Pending word wins; ready is low so no accept can collide.
                        if (pend_full) begin
                            shreg     <= pend;
                            pend_full <= 1'b0;
                            cnt       <= '0;
                        end else if (accept) begin
                            shreg <= bus.load_data;
                            cnt   <= '0;
                        end else begin
                            shreg <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        shreg <= shreg_next;
                        cnt   <= cnt + CW'(1);
                        if (accept) begin
                            pend      <= bus.load_data;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state; zeros while idle.
    assign bus.load_ready = !pend_full;
    assign bus.out_valid  = (state == SHIFT);
    assign bus.out_bit    = (state == SHIFT) && cur_bit;
    assign bus.last_bit   = end_of_word;
    assign bus.busy       = (state == SHIFT) || pend_full;

endmodule

// File: tb/tb_par2ser_bit_feeder.sv
// Self-checking bench for par2ser_bit_feeder: one MSB-first and one LSB-first
// instance, checked against a word-queue reference model of the serial stream.
module tb_par2ser_bit_feeder;

    localparam int unsigned W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    par2ser_bit_feeder_if #(.WIDTH(W)) if_m ();
    par2ser_bit_feeder_if #(.WIDTH(W)) if_l ();

    par2ser_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m)
    );

    par2ser_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l)
    );

    logic         drv_valid = 1'b0;
    logic [W-1:0] drv_data  = '0;
    bit           sel_lsb   = 1'b0;

    assign if_m.load_valid = drv_valid && !sel_lsb;
    assign if_l.load_valid = drv_valid && sel_lsb;
    assign if_m.load_data  = drv_data;
    assign if_l.load_data  = drv_data;

    logic o_ready, o_valid, o_bit, o_last, o_busy;
    assign o_ready = sel_lsb ? if_l.load_ready : if_m.load_ready;
    assign o_valid = sel_lsb ? if_l.out_valid  : if_m.out_valid;
    assign o_bit   = sel_lsb ? if_l.out_bit    : if_m.out_bit;
    assign o_last  = sel_lsb ? if_l.last_bit   : if_m.last_bit;
    assign o_busy  = sel_lsb ? if_l.busy       : if_m.busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of accepted words (head is being serialized)
    // and the index of the bit currently on the wire.
    logic [W-1:0] mq[$];
    int           midx = 0;

    // Expected {load_ready, out_valid, out_bit, last_bit, busy}.
    function automatic logic [4:0] m_obs();
        logic b = 1'b0;
        logic l = 1'b0;
        logic [W-1:0] head;
        if (mq.size() > 0) begin
            head = mq[0];
            b = sel_lsb ? head[midx] : head[W-1-midx];
            l = (midx == W - 1);
        end
        return {mq.size() < 2, mq.size() > 0, b, l, mq.size() > 0};
    endfunction

    // Drive one cycle of stimulus and advance the model across the edge.
    task automatic step(input bit v, input logic [W-1:0] d);
        bit acc;
        acc       = v && (mq.size() < 2);
        drv_valid = v;
        drv_data  = d;
        @(posedge clk);
        if (mq.size() > 0) begin
            midx++;
            if (midx == W) begin
                void'(mq.pop_front());
                midx = 0;
            end
        end
        if (acc) mq.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        drv_valid = 1'b0;
        reset     = 1'b0;
        mq.delete();
        midx = 0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        drv_valid = 1'b0;
        reset     = 1'b0;
        mq.delete();
        midx = 0;
        #12;
        got = {if_m.load_ready, if_m.out_valid, if_m.out_bit, if_m.last_bit, if_m.busy};
        n_chk++;
        if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_msb got=%b exp=%b", got, 5'b10000);
        end
        got = {if_l.load_ready, if_l.out_valid, if_l.out_bit, if_l.last_bit, if_l.busy};
        n_chk++;
        if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_lsb got=%b exp=%b", got, 5'b10000);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            got = {o_ready, o_valid, o_bit, o_last, o_busy};
            n_chk++;
            if (got !== m_obs()) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d got=%b exp=%b", c, got, m_obs());
            end
            step(1'b0, '0);
        end
    endtask

    // Load one word and compare the serialized stream against a constant.
    task automatic test_word(input bit lsb, input logic [W-1:0] w,
                             input logic [W-1:0] exp_stream, input string tag);
        logic [4:0]   got;
        logic [W-1:0] stream = '0;
        int nv = 0, nlast = 0, lastpos = 0;
        sel_lsb = lsb;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            got = {o_ready, o_valid, o_bit, o_last, o_busy};
            n_chk++;
            if (got !== m_obs()) begin
                n_fail++;
                $display("FAIL %s cyc%0d got=%b exp=%b", tag, c, got, m_obs());
            end
            if (o_valid) begin
                stream = {stream[W-2:0], o_bit};
                nv++;
                if (o_last) begin
                    nlast++;
                    lastpos = nv;
                end
            end
            step(c == 0, w);
        end
        n_chk++;
        if (stream !== exp_stream) begin
            n_fail++;
            $display("FAIL %s_stream got=%b exp=%b", tag, stream, exp_stream);
        end
        n_chk++;
        if (nv != 8 || nlast != 1 || lastpos != 8) begin
            n_fail++;
            $display("FAIL %s_framing got nv=%0d nlast=%0d lastpos=%0d exp 8/1/8",
                     tag, nv, nlast, lastpos);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  got;
        logic [15:0] stream = '0;
        int k = 0, run = 0, maxrun = 0, nlow = 0;
        bit v, acc;
        logic [W-1:0] d;
        sel_lsb = 1'b0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            got = {o_ready, o_valid, o_bit, o_last, o_busy};
            n_chk++;
            if (got !== m_obs()) begin
                n_fail++;
                $display("FAIL b2b cyc%0d got=%b exp=%b", c, got, m_obs());
            end
            if (o_valid) begin
                run++;
                stream = {stream[14:0], o_bit};
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
            if (!o_ready) nlow++;
            v   = (k < 2);
            d   = (k == 0) ? 8'hD0 : 8'hFF;
            acc = v && (mq.size() < 2);
            step(v, d);
            if (acc) k++;
        end
        n_chk++;
        if (maxrun != 16 || nlow != 7) begin
            n_fail++;
            $display("FAIL b2b_contig got run=%0d ready_low=%0d exp 16/7", maxrun, nlow);
        end
        n_chk++;
        if (stream !== 16'hD0FF) begin
            n_fail++;
            $display("FAIL b2b_stream got=%h exp=%h", stream, 16'hD0FF);
        end
    endtask

    task automatic test_reset_midword();
        logic [4:0]   got;
        logic [W-1:0] stream = '0;
        int nv = 0;
        sel_lsb = 1'b0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            got = {o_ready, o_valid, o_bit, o_last, o_busy};
            n_chk++;
            if (got !== m_obs()) begin
                n_fail++;
                $display("FAIL rst_mid_pre cyc%0d got=%b exp=%b", c, got, m_obs());
            end
            step(c < 2, (c == 0) ? 8'hFF : 8'hAA);
        end
        // Third bit of FF on the wire, AA pending.
        got = {o_ready, o_valid, o_bit, o_last, o_busy};
        n_chk++;
        if (got !== 5'b01101) begin
            n_fail++;
            $display("FAIL rst_mid_loaded got=%b exp=%b", got, 5'b01101);
        end
        #1 reset = 1'b0;
        #1;
        got = {o_ready, o_valid, o_bit, o_last, o_busy};
        n_chk++;
        if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL rst_mid_async got=%b exp=%b", got, 5'b10000);
        end
        mq.delete();
        midx = 0;
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 12; c++) begin
            got = {o_ready, o_valid, o_bit, o_last, o_busy};
            n_chk++;
            if (got !== m_obs()) begin
                n_fail++;
                $display("FAIL rst_mid_post cyc%0d got=%b exp=%b", c, got, m_obs());
            end
            if (o_valid) nv++;
            step(1'b0, 8'hAA);
        end
        n_chk++;
        if (nv != 0) begin
            n_fail++;
            $display("FAIL rst_mid_resume got=%0d bits exp=0", nv);
        end
        for (int c = 0; c < 10; c++) begin
            got = {o_ready, o_valid, o_bit, o_last, o_busy};
            n_chk++;
            if (got !== m_obs()) begin
                n_fail++;
                $display("FAIL rst_mid_new cyc%0d got=%b exp=%b", c, got, m_obs());
            end
            if (o_valid) stream = {stream[W-2:0], o_bit};
            step(c == 0, 8'h5A);
        end
        n_chk++;
        if (stream !== 8'h5A) begin
            n_fail++;
            $display("FAIL rst_mid_newword got=%h exp=%h", stream, 8'h5A);
        end
    endtask

    // Behavioural 1101 overlapping detector on the serial stream (gaps included).
    task automatic test_detector_chain();
        logic [4:0]   got;
        logic [3:0]   hist = '0;
        logic [W-1:0] mask = '0;
        int nv = 0, nfire = 0;
        sel_lsb = 1'b0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            got = {o_ready, o_valid, o_bit, o_last, o_busy};
            n_chk++;
            if (got !== m_obs()) begin
                n_fail++;
                $display("FAIL det cyc%0d got=%b exp=%b", c, got, m_obs());
            end
            hist = {hist[2:0], o_bit};
            if (o_valid) nv++;
            if (hist == 4'b1101) begin
                nfire++;
                if (o_valid && nv > 0) mask[nv-1] = 1'b1;
            end
            step(c == 0, 8'hDA);
        end
        n_chk++;
        if (mask !== 8'h48 || nfire != 2) begin
            n_fail++;
            $display("FAIL det_hits got mask=%b fires=%0d exp mask=%b fires=2",
                     mask, nfire, 8'h48);
        end
    endtask

    // New word offered exactly on each end-of-word edge; pending stays empty.
    task automatic test_stream_eow();
        logic [4:0]   got;
        logic [W-1:0] sent[$];
        logic [W-1:0] rcvd[$];
        logic [W-1:0] cur = '0;
        logic [W-1:0] d;
        int k = 0, nb = 0, run = 0, maxrun = 0;
        bit v, acc;
        sel_lsb = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) sent.push_back(W'($urandom));
        for (int c = 0; c < 40; c++) begin
            got = {o_ready, o_valid, o_bit, o_last, o_busy};
            n_chk++;
            if (got !== m_obs()) begin
                n_fail++;
                $display("FAIL eow cyc%0d got=%b exp=%b", c, got, m_obs());
            end
            if (o_valid) begin
                run++;
                cur = {cur[W-2:0], o_bit};
                nb++;
                if (nb == W) begin
                    rcvd.push_back(cur);
                    nb = 0;
                end
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
            v   = (k < 4) && ((mq.size() == 0) ? (c == 0) : (midx == W - 1));
            d   = (k < 4) ? sent[k] : '0;
            acc = v && (mq.size() < 2);
            step(v, d);
            if (acc) k++;
        end
        n_chk++;
        if (maxrun != 32 || rcvd.size() != 4) begin
            n_fail++;
            $display("FAIL eow_contig got run=%0d words=%0d exp 32/4", maxrun, rcvd.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < rcvd.size()) begin
                n_chk++;
                if (rcvd[i] !== sent[i]) begin
                    n_fail++;
                    $display("FAIL eow_word%0d got=%h exp=%h", i, rcvd[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] got;
        for (int m = 0; m < 2; m++) begin
            sel_lsb = (m == 1);
            do_reset();
            for (int c = 0; c < 300; c++) begin
                got = {o_ready, o_valid, o_bit, o_last, o_busy};
                n_chk++;
                if (got !== m_obs()) begin
                    n_fail++;
                    $display("FAIL rand_m%0d cyc%0d got=%b exp=%b", m, c, got, m_obs());
                end
                step($urandom_range(0, 99) < 60, W'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_word(1'b0, 8'hDA, 8'hDA, "msb_single");
        test_back_to_back();
        test_word(1'b1, 8'h0B, 8'hD0, "lsb_single");
        test_reset_midword();
        test_detector_chain();
        test_stream_eow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

endmodule
